// File: rtl/shift_mult_seq.sv
// Serial shift-add fractional multiplier: y = floor(a*b / 2^B_WIDTH), one multiplier bit per cycle,
// unsigned or two's-complement operands, optional round-half-up, valid/ready on both sides.
`timescale 1ns/1ps
module shift_mult_seq #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 8,
    parameter int ROUND   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH-1:0] y,
    output logic [B_WIDTH-1:0] y_lo
);
    localparam int CNT_W = $clog2(B_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(B_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

    state_t                     state_q;
    logic        [A_WIDTH-1:0]  a_q;
    logic        [B_WIDTH-1:0]  b_q;
    logic                       smode_q;
    logic signed [A_WIDTH:0]    acc_q;
    logic        [B_WIDTH-1:0]  ylo_q;
    logic        [A_WIDTH-1:0]  y_q;
    logic        [CNT_W-1:0]    cnt_q;
    logic signed [A_WIDTH+1:0]  sum_d;

    // The multiplier MSB carries negative weight in two's complement, so the last step subtracts.
    function automatic logic signed [A_WIDTH+1:0] step_sum(
        input logic signed [A_WIDTH:0]   acc,
        input logic        [A_WIDTH-1:0] mcand,
        input logic                      smode,
        input logic                      bit0,
        input logic                      last
    );
        logic signed [A_WIDTH+1:0] addend;
        logic signed [A_WIDTH+1:0] acc_x;
        addend = '0;
        if (bit0) begin
            addend = smode ? {{2{mcand[A_WIDTH-1]}}, mcand} : {2'b00, mcand};
        end
        acc_x = {acc[A_WIDTH], acc};
        return (smode && last) ? (acc_x - addend) : (acc_x + addend);
    endfunction

    function automatic logic [A_WIDTH-1:0] round_y(
        input logic [A_WIDTH-1:0] hi,
        input logic               half
    );
        if (ROUND != 0) begin
            return hi + {{(A_WIDTH-1){1'b0}}, half};
        end
        return hi;
    endfunction

    always_comb begin
        sum_d = step_sum(acc_q, a_q, smode_q, b_q[0], cnt_q == LAST_STEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            smode_q <= 1'b0;
            acc_q   <= '0;
            ylo_q   <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else if (abort) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        smode_q <= signed_mode;
                        acc_q   <= '0;
                        ylo_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= sum_d[A_WIDTH+1:1];
                    ylo_q <= {sum_d[0], ylo_q[B_WIDTH-1:1]};
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    y_q     <= round_y(acc_q[A_WIDTH-1:0], ylo_q[B_WIDTH-1]);
                    state_q <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign y_lo      = ylo_q;
endmodule

// File: tb/tb_shift_mult_seq.sv
// Bench for shift_mult_seq: truncating and rounding instances share stimulus and are checked every
// cycle against an arithmetic reference of the product, plus hand-computed directed cases.
`timescale 1ns/1ps
module tb_shift_mult_seq;
    localparam int AW = 16;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          abort;
    logic          in_valid;
    logic          signed_mode;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          out_ready;
    logic          in_ready0, in_ready1, out_valid0, out_valid1;
    logic [AW-1:0] y0, y1;
    logic [BW-1:0] ylo0, ylo1;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    shift_mult_seq #(.A_WIDTH(AW), .B_WIDTH(BW), .ROUND(0)) u_trunc (
        .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(in_ready0),
        .signed_mode(signed_mode), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .y(y0), .y_lo(ylo0)
    );

    shift_mult_seq #(.A_WIDTH(AW), .B_WIDTH(BW), .ROUND(1)) u_round (
        .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(in_ready1),
        .signed_mode(signed_mode), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .y(y1), .y_lo(ylo1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact product in a wide integer, then shift and optional half-up.
    function automatic void model(input logic [AW-1:0] av, input logic [BW-1:0] bv, input logic sv,
                                  output logic [AW-1:0] ty, output logic [AW-1:0] ry,
                                  output logic [BW-1:0] lo);
        longint p, q;
        int     half;
        if (sv) p = longint'($signed(av)) * longint'($signed(bv));
        else    p = longint'(av) * longint'(bv);
        q    = p >>> BW;
        half = p[BW-1] ? 1 : 0;
        lo   = p[BW-1:0];
        ty   = q[AW-1:0];
        q    = q + longint'(half);
        ry   = q[AW-1:0];
    endfunction

    logic          pending   = 1'b0;
    int            age       = 0;
    logic [AW-1:0] exp_y0, exp_y1, last_y0 = '0, last_y1 = '0;
    logic [BW-1:0] exp_lo, last_lo = '0;
    logic          lo_known  = 1'b1;

    // Transaction-level model: one operation in flight, result visible BW+1 cycles after acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending = 1'b0; age = 0;
            last_y0 = '0; last_y1 = '0; last_lo = '0; lo_known = 1'b1;
        end else if (abort) begin
            if (pending && age >= BW + 1) begin
                last_y0 = exp_y0; last_y1 = exp_y1; last_lo = exp_lo; lo_known = 1'b1;
            end
            pending = 1'b0;
        end else if (pending) begin
            if (age >= BW + 1 && out_ready) begin
                last_y0 = exp_y0; last_y1 = exp_y1; last_lo = exp_lo; lo_known = 1'b1;
                pending = 1'b0;
            end else begin
                age++;
            end
        end else if (in_valid) begin
            model(a, b, signed_mode, exp_y0, exp_y1, exp_lo);
            pending  = 1'b1;
            age      = 0;
            lo_known = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic done;
        done = pending && (age >= BW + 1);
        chk("in_ready_trunc",  32'(in_ready0),  32'(!pending));
        chk("in_ready_round",  32'(in_ready1),  32'(!pending));
        chk("out_valid_trunc", 32'(out_valid0), 32'(done));
        chk("out_valid_round", 32'(out_valid1), 32'(done));
        chk("y_trunc", 32'(y0), 32'(done ? exp_y0 : last_y0));
        chk("y_round", 32'(y1), 32'(done ? exp_y1 : last_y1));
        if (done || lo_known) begin
            chk("y_lo_trunc", 32'(ylo0), 32'(done ? exp_lo : last_lo));
            chk("y_lo_round", 32'(ylo1), 32'(done ? exp_lo : last_lo));
        end
    end

    task automatic do_op(input logic [AW-1:0] av, input logic [BW-1:0] bv, input logic sv,
                         input int stall, output logic [AW-1:0] ry0, output logic [AW-1:0] ry1,
                         output logic [BW-1:0] rlo, output int lat, output longint acc_cyc);
        a = av; b = bv; signed_mode = sv; in_valid = 1'b1;
        acc_cyc = cyc + 1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = AW'($urandom); b = BW'($urandom); signed_mode = 1'($urandom);
        lat = 0;
        while (!out_valid0 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid0) chk("out_valid_timeout", 32'(out_valid0), 32'd1);
        ry0 = y0; ry1 = y1; rlo = ylo0;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom); a = AW'($urandom); b = BW'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (stall > 0) begin
            chk("hold_y",        32'(y0),        32'(ry0));
            chk("hold_y_lo",     32'(ylo0),      32'(rlo));
            chk("hold_in_ready", 32'(in_ready0), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] r0, r1, ra, rb;
        logic [BW-1:0] rl;
        int            lat, seen;
        longint        c1, c2;

        rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; signed_mode = 1'b0;
        #1;
        chk("rst_in_ready",  32'(in_ready0),  32'd1);
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_y",         32'(y0),         32'd0);
        chk("rst_y_lo",      32'(ylo0),       32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        do_op(16'hFFFF, 8'hFF, 1'b0, 0, r0, r1, rl, lat, c1);
        chk("umax_y",   32'(r0),  32'h0000FEFF);
        chk("umax_yr",  32'(r1),  32'h0000FEFF);
        chk("umax_ylo", 32'(rl),  32'h01);
        chk("latency",  32'(lat), 32'd9);

        do_op(16'h8000, 8'h80, 1'b1, 2, r0, r1, rl, lat, c1);
        chk("smin_y",   32'(r0), 32'h4000);
        chk("smin_yr",  32'(r1), 32'h4000);
        chk("smin_ylo", 32'(rl), 32'h00);

        do_op(16'h0003, 8'hFF, 1'b1, 5, r0, r1, rl, lat, c1);
        chk("neg3_y",   32'(r0), 32'hFFFF);
        chk("neg3_yr",  32'(r1), 32'h0000);
        chk("neg3_ylo", 32'(rl), 32'hFD);

        do_op(16'h0001, 8'h80, 1'b0, 0, r0, r1, rl, lat, c1);
        chk("half_y",   32'(r0), 32'h0000);
        chk("half_yr",  32'(r1), 32'h0001);
        chk("half_ylo", 32'(rl), 32'h80);

        do_op(16'h0001, 8'h7F, 1'b0, 0, r0, r1, rl, lat, c1);
        chk("below_half_yr", 32'(r1), 32'h0000);

        do_op(16'h1234, 8'h56, 1'b0, 0, r0, r1, rl, lat, c1);
        do_op(16'h4321, 8'h65, 1'b1, 0, r0, r1, rl, lat, c2);
        chk("issue_period", 32'(c2 - c1), 32'd11);

        // Reset in the middle of a run.
        a = 16'hABCD; b = 8'h5A; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_y",         32'(y0),         32'd0);
        chk("midrst_y_lo",      32'(ylo0),       32'd0);
        chk("midrst_out_valid", 32'(out_valid0), 32'd0);
        chk("midrst_in_ready",  32'(in_ready0),  32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        do_op(16'h0100, 8'h40, 1'b0, 0, r0, r1, rl, lat, c1);
        chk("postrst_y", 32'(r0), 32'h0040);

        // Abort during run, then abort colliding with a request in IDLE.
        a = 16'h7777; b = 8'h33; signed_mode = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_in_ready",  32'(in_ready0),  32'd1);
        chk("abort_out_valid", 32'(out_valid0), 32'd0);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid0) seen++;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        abort = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 abort = 1'b0; in_valid = 1'b0;
        chk("abort_vs_accept", 32'(in_ready0), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 2000; i++) begin
            logic s;
            s = i[0];
            case ($urandom_range(0, 7))
                0:       ra = 16'h0000;
                1:       ra = 16'hFFFF;
                2:       ra = 16'h8000;
                3:       ra = 16'h7FFF;
                default: ra = AW'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 16'h0000;
                1:       rb = 16'h00FF;
                2:       rb = 16'h0080;
                3:       rb = 16'h007F;
                default: rb = AW'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            do_op(ra, rb[BW-1:0], s, int'($urandom_range(0, 3)), r0, r1, rl, lat, c1);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
